// File: rtl/axis_tkeep_fifo.sv
// AXI-Stream FIFO that stores tkeep as a compact "last valid byte" index
// and presents a fully registered read side (data, keep, last, valid).
module axis_tkeep_fifo #(
    parameter int DATA_WIDTH      = 256,
    parameter int TKEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int DEPTH           = 16,
    parameter int TKEEP_ENC_WIDTH = $clog2(TKEEP_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [TKEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   fill_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + TKEEP_ENC_WIDTH + 1;
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [EW-1:0]              r_mem [DEPTH];
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [AW:0]                r_mem_count;
    logic [AW:0]                r_fill;
    logic [DATA_WIDTH-1:0]      r_m_tdata;
    logic [TKEEP_WIDTH-1:0]     r_m_tkeep;
    logic                       r_m_tlast;
    logic                       r_m_tvalid;

    logic                       w_wr;
    logic                       w_rd;
    logic                       w_load;
    logic [TKEEP_ENC_WIDTH-1:0] w_enc;
    logic [EW-1:0]              w_rd_entry;
    logic [TKEEP_ENC_WIDTH-1:0] w_rd_enc;
    logic [TKEEP_WIDTH-1:0]     w_keep_dec;

    // tready comes only from the registered fill level, never from m_axis_tready
    assign s_axis_tready = !reset && (r_fill < CNT_FULL);
    assign w_wr          = s_axis_tvalid && s_axis_tready;
    assign w_rd          = r_m_tvalid && m_axis_tready;
    assign w_load        = (r_mem_count != '0) && (!r_m_tvalid || m_axis_tready);

    // Index of the last kept byte: one below the first zero above bit 0
    always_comb begin
        w_enc = TKEEP_ENC_WIDTH'(TKEEP_WIDTH - 1);
        for (int i = TKEEP_WIDTH - 1; i >= 1; i--) begin
            if (!s_axis_tkeep[i]) begin
                w_enc = TKEEP_ENC_WIDTH'(i - 1);
            end
        end
    end

    assign w_rd_entry = r_mem[r_rd_ptr];
    assign w_rd_enc   = w_rd_entry[TKEEP_ENC_WIDTH:1];

    always_comb begin
        w_keep_dec = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++) begin
            w_keep_dec[i] = (i <= int'(w_rd_enc));
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {s_axis_tdata, w_enc, s_axis_tlast};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_fill      <= '0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_tlast   <= 1'b0;
            r_m_tvalid  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_load) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_m_tdata  <= w_rd_entry[EW-1 -: DATA_WIDTH];
                r_m_tkeep  <= w_keep_dec;
                r_m_tlast  <= w_rd_entry[0];
                r_m_tvalid <= 1'b1;
            end else if (w_rd) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_wr && !w_load) begin
                r_mem_count <= r_mem_count + CNT_ONE;
            end else if (!w_wr && w_load) begin
                r_mem_count <= r_mem_count - CNT_ONE;
            end

            // fill includes the beat parked in the output register
            if (w_wr && !w_rd) begin
                r_fill <= r_fill + CNT_ONE;
            end else if (!w_wr && w_rd) begin
                r_fill <= r_fill - CNT_ONE;
            end
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tvalid = r_m_tvalid;
    assign fill_count    = r_fill;

endmodule
